// File: rtl/filter_arbiter.sv
// Round-robin arbiter sharing one fixed-latency filter among NUM_REQ requesters,
// with a tag delay line routing results back. Define FILTER_ARB_STATS_EN for grant/drop counters.
module filter_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TAG_W          = 2,
    parameter int unsigned FILTER_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ*16-1:0]   req_data,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ-1:0]      req_parity,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [15:0]             fx_data,
    output logic                    fx_valid,
    output logic                    fx_parity,
    input  logic [15:0]             fy_data,
    input  logic                    fy_valid,
    input  logic                    fy_parity,
    output logic [15:0]             resp_data,
    output logic                    resp_parity,
    output logic [NUM_REQ-1:0]      resp_valid,
    output logic                    err
`ifdef FILTER_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]   grant_count,
    output logic [7:0]              drop_count
`endif
);

    logic [TAG_W-1:0]          last_grant_q, last_grant_d;
    logic [15:0]               fx_data_q, fx_data_d;
    logic                      fx_parity_q, fx_parity_d;
    logic                      fx_valid_q, fx_valid_d;
    logic                      err_q, err_d;

    logic [TAG_W-1:0]          gnt_idx;
    logic                      gnt_found;
    logic [NUM_REQ-1:0]        gnt_onehot;
    logic                      transfer;
    int unsigned               scan_idx;

    logic [FILTER_LATENCY-1:0] tag_v_q;
    logic [TAG_W-1:0]          tag_t_q [FILTER_LATENCY];
    logic                      head_v;
    logic [TAG_W-1:0]          head_t;
    logic                      mismatch;

    // Scan starts one past the previous winner, so the last winner has lowest priority.
    always_comb begin
        gnt_idx    = '0;
        gnt_found  = 1'b0;
        scan_idx   = 0;
        gnt_onehot = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            scan_idx = (32'(last_grant_q) + 32'd1 + k) % NUM_REQ;
            if (!gnt_found && req_valid[scan_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = TAG_W'(scan_idx);
            end
        end
        if (gnt_found && !reset) begin
            gnt_onehot[gnt_idx] = 1'b1;
        end
    end

    assign req_ready = gnt_onehot;
    assign transfer  = gnt_found && !reset;

    always_comb begin
        last_grant_d = last_grant_q;
        fx_data_d    = fx_data_q;
        fx_parity_d  = fx_parity_q;
        fx_valid_d   = 1'b0;
        if (transfer) begin
            last_grant_d = gnt_idx;
            fx_data_d    = req_data[16*gnt_idx +: 16];
            fx_parity_d  = req_parity[gnt_idx];
            fx_valid_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= TAG_W'(NUM_REQ - 1);
            fx_data_q    <= '0;
            fx_parity_q  <= 1'b0;
            fx_valid_q   <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            fx_data_q    <= fx_data_d;
            fx_parity_q  <= fx_parity_d;
            fx_valid_q   <= fx_valid_d;
        end
    end

    assign fx_data   = fx_data_q;
    assign fx_parity = fx_parity_q;
    assign fx_valid  = fx_valid_q;

    // While fx_valid_q is high, last_grant_q still holds the index that was issued.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_v_q <= '0;
            for (int unsigned i = 0; i < FILTER_LATENCY; i++) begin
                tag_t_q[i] <= '0;
            end
        end else begin
            tag_v_q[0] <= fx_valid_q;
            tag_t_q[0] <= last_grant_q;
            for (int unsigned i = 1; i < FILTER_LATENCY; i++) begin
                tag_v_q[i] <= tag_v_q[i-1];
                tag_t_q[i] <= tag_t_q[i-1];
            end
        end
    end

    assign head_v   = tag_v_q[FILTER_LATENCY-1];
    assign head_t   = tag_t_q[FILTER_LATENCY-1];
    assign mismatch = (fy_valid != head_v) && !reset;

    always_comb begin
        resp_valid = '0;
        if (fy_valid && head_v && !reset) begin
            resp_valid[head_t] = 1'b1;
        end
    end

    assign resp_data   = fy_data;
    assign resp_parity = fy_parity;

    assign err_d = err_q | mismatch;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;

`ifdef FILTER_ARB_STATS_EN
    logic [NUM_REQ*16-1:0] grant_count_q;
    logic [7:0]            drop_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            grant_count_q <= '0;
            drop_count_q  <= '0;
        end else begin
            if (transfer) begin
                grant_count_q[16*gnt_idx +: 16] <= grant_count_q[16*gnt_idx +: 16] + 16'd1;
            end
            if (mismatch && drop_count_q != 8'hFF) begin
                drop_count_q <= drop_count_q + 8'd1;
            end
        end
    end

    assign grant_count = grant_count_q;
    assign drop_count  = drop_count_q;
`endif

endmodule
